sha256_pad_ctrl: RTL and testbench

//  Message front-end and sequencer for one sha256 core. Takes a 32-bit big-endian word stream, builds
//  and FIPS-180-4 pads 512-bit blocks, and issues them one at a time with new_hash on the first block.

---
 rtl/sha256_pkg.sv | 38 +++
 rtl/sha256_pad_block.sv | 36 +++
 rtl/sha256_pad_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_sha256_pad_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the sha256 message front-end: block/digest widths,
// the initial hash value, controller states, pad-block modes and the byte padding helper.
package sha256_pkg;

    localparam int BLOCK_W  = 512;
    localparam int DIGEST_W = 256;

    localparam logic [DIGEST_W-1:0] SHA256_IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    typedef enum logic [2:0] {
        PS_IDLE,
        PS_FILL,
        PS_ISSUE,
        PS_WAIT,
        PS_PADBLK,
        PS_DONE
    } pad_state_e;

    typedef enum logic [1:0] {
        PM_RAW,
        PM_TAIL,
        PM_PAD
    } pad_mode_e;

    // Message byte below n, the 0x80 marker at n, zero past it.
    function automatic logic [7:0] pad_byte(input logic [7:0] data,
                                            input logic [6:0] pos,
                                            input logic [6:0] n);
        if (pos < n)
            return data;
        else if (pos == n)
            return 8'h80;
        else
            return 8'h00;
    endfunction

endpackage

// File: rtl/sha256_pad_block.sv
// Combinational block former: turns the raw word buffer, the byte count of the tail
// and the 64-bit bit-length into the 512-bit block handed to the core.
module sha256_pad_block
    import sha256_pkg::*;
(
    input  logic [BLOCK_W-1:0] words_i,
    input  logic [6:0]         nbytes_i,
    input  logic [63:0]        len_i,
    input  pad_mode_e          mode_i,
    output logic [BLOCK_W-1:0] block_o
);

    // A tail block only carries the length when at least 8 bytes remain after the marker;
    // otherwise a separate pad block follows, which takes the marker only if the tail had no room.
    always_comb begin
        block_o = words_i;
        case (mode_i)
            PM_TAIL: begin
                for (int i = 0; i < 64; i++) begin
                    block_o[BLOCK_W-1-8*i -: 8] =
                        pad_byte(words_i[BLOCK_W-1-8*i -: 8], 7'(i), nbytes_i);
                end
                if (nbytes_i <= 7'd55)
                    block_o[63:0] = len_i;
            end
            PM_PAD: begin
                block_o = '0;
                if (nbytes_i == 7'd64)
                    block_o[BLOCK_W-1 -: 8] = 8'h80;
                block_o[63:0] = len_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sha256_pad_ctrl.sv
// Message front-end and block sequencer for one sha256 core: collects 32-bit words, pads,
// issues blocks one at a time and returns the digest. SHA256_PAD_PERF_EN adds blk_count.
module sha256_pad_ctrl
    import sha256_pkg::*;
#(
    parameter int LEN_W = 32
)
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                msg_valid,
    output logic                msg_ready,
    input  logic [31:0]         msg_data,
    input  logic                msg_last,
    input  logic [1:0]          msg_bytes,
    output logic                core_in_valid,
    output logic [BLOCK_W-1:0]  core_in,
    output logic                core_new_hash,
    input  logic                core_in_ready,
    input  logic                core_out_valid,
    input  logic [DIGEST_W-1:0] core_out,
    output logic                core_out_ready,
    output logic                digest_valid,
    output logic [DIGEST_W-1:0] digest,
    input  logic                digest_ready
`ifdef SHA256_PAD_PERF_EN
    ,
    output logic [31:0]         blk_count
`endif
);

    pad_state_e          state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                first_q, first_d;
    logic                final_q, final_d;
    logic                pend_q, pend_d;
    logic [6:0]          nbytes_q, nbytes_d;
    pad_mode_e           mode_q, mode_d;
    logic [0:15][31:0]   words_q, words_d;
    logic [DIGEST_W-1:0] digest_q, digest_d;
    logic                dvalid_q, dvalid_d;

    logic                msg_fire;
    logic                core_fire;
    logic [2:0]          word_bytes;
    logic [6:0]          fill_n;
    logic [63:0]         len_field;

    assign word_bytes = (msg_last && msg_bytes != 2'd0) ? {1'b0, msg_bytes} : 3'd4;
    assign fill_n     = {1'b0, idx_q, 2'b00} + {4'b0000, word_bytes};
    assign len_field  = {{(61-LEN_W){1'b0}}, cnt_q, 3'b000};

    // msg_ready is gated by reset so it reads 0 while reset is held even though the state is IDLE.
    assign msg_ready      = !rst_i && (state_q == PS_IDLE || state_q == PS_FILL);
    assign msg_fire       = msg_valid && msg_ready;
    assign core_in_valid  = (state_q == PS_ISSUE) && core_in_ready;
    assign core_fire      = core_in_valid && core_in_ready;
    assign core_new_hash  = (state_q == PS_ISSUE) && first_q;
    assign core_out_ready = (state_q == PS_WAIT);
    assign digest_valid   = dvalid_q;
    assign digest         = digest_q;

    sha256_pad_block u_pad_block (
        .words_i  (words_q),
        .nbytes_i (nbytes_q),
        .len_i    (len_field),
        .mode_i   (mode_q),
        .block_o  (core_in)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        final_d  = final_q;
        pend_d   = pend_q;
        nbytes_d = nbytes_q;
        mode_d   = mode_q;
        words_d  = words_q;
        digest_d = digest_q;
        dvalid_d = dvalid_q;

        case (state_q)
            PS_IDLE, PS_FILL: begin
                if (msg_fire) begin
                    words_d[idx_q] = msg_data;
                    idx_d          = idx_q + 4'd1;
                    cnt_d          = cnt_q + LEN_W'(word_bytes);
                    if (msg_last) begin
                        mode_d   = PM_TAIL;
                        nbytes_d = fill_n;
                        final_d  = (fill_n <= 7'd55);
                        pend_d   = (fill_n > 7'd55);
                        state_d  = PS_ISSUE;
                    end else if (idx_q == 4'd15) begin
                        mode_d  = PM_RAW;
                        final_d = 1'b0;
                        pend_d  = 1'b0;
                        state_d = PS_ISSUE;
                    end else begin
                        state_d = PS_FILL;
                    end
                end
            end
            PS_ISSUE: begin
                if (core_fire) begin
                    first_d = 1'b0;
                    state_d = PS_WAIT;
                end
            end
            PS_WAIT: begin
                if (core_out_valid) begin
                    if (final_q) begin
                        digest_d = core_out;
                        dvalid_d = 1'b1;
                        state_d  = PS_DONE;
                    end else if (pend_q) begin
                        state_d = PS_PADBLK;
                    end else begin
                        idx_d   = 4'd0;
                        state_d = PS_FILL;
                    end
                end
            end
            PS_PADBLK: begin
                mode_d  = PM_PAD;
                final_d = 1'b1;
                pend_d  = 1'b0;
                state_d = PS_ISSUE;
            end
            PS_DONE: begin
                if (digest_ready) begin
                    dvalid_d = 1'b0;
                    cnt_d    = '0;
                    first_d  = 1'b1;
                    idx_d    = 4'd0;
                    state_d  = PS_IDLE;
                end
            end
            default: state_d = PS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= PS_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b1;
            final_q  <= 1'b0;
            pend_q   <= 1'b0;
            nbytes_q <= '0;
            mode_q   <= PM_RAW;
            words_q  <= '0;
            digest_q <= '0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            final_q  <= final_d;
            pend_q   <= pend_d;
            nbytes_q <= nbytes_d;
            mode_q   <= mode_d;
            words_q  <= words_d;
            digest_q <= digest_d;
            dvalid_q <= dvalid_d;
        end
    end

`ifdef SHA256_PAD_PERF_EN
    logic [31:0] blk_count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            blk_count_q <= '0;
        else if (core_fire && blk_count_q != 32'hFFFF_FFFF)
            blk_count_q <= blk_count_q + 32'd1;
    end

    assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_sha256_pad_ctrl.sv
// Directed bench for sha256_pad_ctrl driving a behavioural sha256 core (result two cycles
// after each accepted block). Define SHA256_PAD_PERF_EN to also check blk_count.
module tb_sha256_pad_ctrl;
    import sha256_pkg::*;

    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIG =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          msg_valid = 1'b0;
    logic          msg_ready;
    logic [31:0]   msg_data = '0;
    logic          msg_last = 1'b0;
    logic [1:0]    msg_bytes = '0;
    logic          core_in_valid;
    logic [511:0]  core_in;
    logic          core_new_hash;
    logic          core_in_ready;
    logic          core_out_valid;
    logic [255:0]  core_out;
    logic          core_out_ready;
    logic          digest_valid;
    logic [255:0]  digest;
    logic          digest_ready = 1'b0;
`ifdef SHA256_PAD_PERF_EN
    logic [31:0]   blk_count;
`endif

    logic          coreHold = 1'b0;
    logic          busy;
    logic          outValid;
    logic [1:0]    delay;
    logic [255:0]  chain;
    logic [255:0]  resQ;

    logic [511:0]  blkLog [$];
    bit            nhLog [$];
    logic [31:0]   msgWords [0:15];

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    sha256_pad_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .msg_valid      (msg_valid),
        .msg_ready      (msg_ready),
        .msg_data       (msg_data),
        .msg_last       (msg_last),
        .msg_bytes      (msg_bytes),
        .core_in_valid  (core_in_valid),
        .core_in        (core_in),
        .core_new_hash  (core_new_hash),
        .core_in_ready  (core_in_ready),
        .core_out_valid (core_out_valid),
        .core_out       (core_out),
        .core_out_ready (core_out_ready),
        .digest_valid   (digest_valid),
        .digest         (digest),
        .digest_ready   (digest_ready)
`ifdef SHA256_PAD_PERF_EN
        ,
        .blk_count      (blk_count)
`endif
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hIn, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hIn;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hIn[255:224], b + hIn[223:192], c + hIn[191:160], d + hIn[159:128],
                e + hIn[127:96],  f + hIn[95:64],   g + hIn[63:32],   h + hIn[31:0]};
    endfunction

    // Behavioural core: one block in flight, result two cycles after the accepting edge.
    assign core_in_ready  = !busy && !coreHold;
    assign core_out_valid = outValid;
    assign core_out       = resQ;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy     <= 1'b0;
            outValid <= 1'b0;
            delay    <= 2'd0;
            chain    <= SHA256_IV;
            resQ     <= '0;
        end else begin
            if (core_in_valid && core_in_ready) begin
                resQ  <= compress(core_new_hash ? SHA256_IV : chain, core_in);
                busy  <= 1'b1;
                delay <= 2'd2;
            end else if (delay != 2'd0) begin
                delay <= delay - 2'd1;
                if (delay == 2'd1) outValid <= 1'b1;
            end
            if (outValid && core_out_ready) begin
                outValid <= 1'b0;
                busy     <= 1'b0;
                chain    <= resQ;
            end
        end
    end

    always @(posedge clk_i) begin
        if (!rst_i && core_in_valid && core_in_ready) begin
            blkLog.push_back(core_in);
            nhLog.push_back(core_new_hash);
        end
    end

    function automatic logic [31:0] blkWord(input int b, input int w);
        logic [511:0] blk;
        blk = blkLog[b];
        return blk[511-32*w -: 32];
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int nWords, input logic [1:0] lastBytes,
                                 input bit gaps, input bit endMsg);
        int waitCyc;
        bit timedOut = 1'b0;
        for (int w = 0; w < nWords; w++) begin
            if (gaps) begin
                msg_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk_i);
            end
            msg_valid = 1'b1;
            msg_data  = msgWords[w];
            msg_last  = endMsg && (w == nWords - 1);
            msg_bytes = (endMsg && (w == nWords - 1)) ? lastBytes : 2'd0;
            waitCyc = 0;
            while (!msg_ready && waitCyc < 200) begin
                @(negedge clk_i);
                waitCyc++;
            end
            if (!msg_ready) timedOut = 1'b1;
            @(negedge clk_i);
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        checkOutput("msgAcceptTimeout", 256'(timedOut), 256'd0);
    endtask

    task automatic collectDigest(input string tag, input logic [255:0] expDig, input bit checkDig);
        int cyc = 0;
        while (!digest_valid && cyc < 500) begin
            @(negedge clk_i);
            cyc++;
        end
        checkOutput({tag, "Valid"}, 256'(digest_valid), 256'd1);
        if (checkDig) checkOutput(tag, digest, expDig);
        digest_ready = 1'b1;
        @(negedge clk_i);
        digest_ready = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic loadTwoBlockText();
        msgWords[0]  = 32'h61626364; msgWords[1]  = 32'h62636465;
        msgWords[2]  = 32'h63646566; msgWords[3]  = 32'h64656667;
        msgWords[4]  = 32'h65666768; msgWords[5]  = 32'h66676869;
        msgWords[6]  = 32'h6768696a; msgWords[7]  = 32'h68696a6b;
        msgWords[8]  = 32'h696a6b6c; msgWords[9]  = 32'h6a6b6c6d;
        msgWords[10] = 32'h6b6c6d6e; msgWords[11] = 32'h6c6d6e6f;
        msgWords[12] = 32'h6d6e6f70; msgWords[13] = 32'h6e6f7071;
    endtask

    task automatic clearWords();
        for (int i = 0; i < 16; i++) msgWords[i] = 32'h0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int cyc;
        logic wasWait;

        repeat (3) @(negedge clk_i);
        checkOutput("rstMsgReady",   256'(msg_ready),      256'd0);
        checkOutput("rstCoreValid",  256'(core_in_valid),  256'd0);
        checkOutput("rstOutReady",   256'(core_out_ready), 256'd0);
        checkOutput("rstDigValid",   256'(digest_valid),   256'd0);
        checkOutput("rstDigest",     digest,               256'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("idleMsgReady",  256'(msg_ready),      256'd1);

        $display("[TB] abc");
        base = blkLog.size();
        msgWords[0] = 32'h61626300;
        applyStimulus(1, 2'd3, 1'b0, 1'b1);
        collectDigest("abcDigest", ABC_DIG, 1'b1);
        checkOutput("abcBlocks", 256'(blkLog.size() - base), 256'd1);
        checkOutput("abcNewHash", 256'(nhLog[base]), 256'd1);
        checkOutput("abcW0",  256'(blkWord(base, 0)),  256'h61626380);
        checkOutput("abcW1",  256'(blkWord(base, 1)),  256'h0);
        checkOutput("abcW15", 256'(blkWord(base, 15)), 256'h18);

        $display("[TB] 56-byte text");
        base = blkLog.size();
        loadTwoBlockText();
        applyStimulus(14, 2'd0, 1'b0, 1'b1);
        collectDigest("twoDigest", TWO_DIG, 1'b1);
        checkOutput("twoBlocks", 256'(blkLog.size() - base), 256'd2);
        checkOutput("twoNh0", 256'(nhLog[base]), 256'd1);
        checkOutput("twoNh1", 256'(nhLog[base+1]), 256'd0);
        checkOutput("twoB0W14", 256'(blkWord(base, 14)), 256'h80000000);
        checkOutput("twoB0W15", 256'(blkWord(base, 15)), 256'h0);
        checkOutput("twoB1W0",  256'(blkWord(base+1, 0)),  256'h0);
        checkOutput("twoB1W15", 256'(blkWord(base+1, 15)), 256'h1c0);

        $display("[TB] zero messages 55/56/64");
        clearWords();
        base = blkLog.size();
        applyStimulus(14, 2'd3, 1'b0, 1'b1);
        collectDigest("z55", '0, 1'b0);
        checkOutput("z55Blocks", 256'(blkLog.size() - base), 256'd1);
        checkOutput("z55W13", 256'(blkWord(base, 13)), 256'h80);
        checkOutput("z55W15", 256'(blkWord(base, 15)), 256'h1b8);

        base = blkLog.size();
        applyStimulus(14, 2'd0, 1'b0, 1'b1);
        collectDigest("z56", '0, 1'b0);
        checkOutput("z56Blocks", 256'(blkLog.size() - base), 256'd2);
        checkOutput("z56B0W14", 256'(blkWord(base, 14)), 256'h80000000);
        checkOutput("z56B1W0",  256'(blkWord(base+1, 0)),  256'h0);
        checkOutput("z56B1W15", 256'(blkWord(base+1, 15)), 256'h1c0);

        base = blkLog.size();
        applyStimulus(16, 2'd0, 1'b0, 1'b1);
        collectDigest("z64", '0, 1'b0);
        checkOutput("z64Blocks", 256'(blkLog.size() - base), 256'd2);
        checkOutput("z64B0W15", 256'(blkWord(base, 15)), 256'h0);
        checkOutput("z64B1W0",  256'(blkWord(base+1, 0)),  256'h80000000);
        checkOutput("z64B1W15", 256'(blkWord(base+1, 15)), 256'h200);
        checkOutput("z64Nh1",   256'(nhLog[base+1]), 256'd0);

        $display("[TB] backpressure");
        loadTwoBlockText();
        applyStimulus(14, 2'd0, 1'b1, 1'b1);
        cyc = 0;
        while (!digest_valid && cyc < 500) begin
            @(negedge clk_i);
            cyc++;
        end
        for (int i = 0; i < 20; i++) begin
            checkOutput("bpDigest",    digest,               TWO_DIG);
            checkOutput("bpDigValid",  256'(digest_valid),   256'd1);
            checkOutput("bpMsgReady",  256'(msg_ready),      256'd0);
            checkOutput("bpCoreValid", 256'(core_in_valid),  256'd0);
            @(negedge clk_i);
        end
        collectDigest("bpFinal", TWO_DIG, 1'b1);

        $display("[TB] reset during WAIT");
        clearWords();
        applyStimulus(16, 2'd0, 1'b0, 1'b0);
        cyc = 0;
        while (!core_out_ready && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        wasWait = core_out_ready;
        checkOutput("reachWait", 256'(wasWait), 256'd1);
        rst_i = 1'b1;
        #1;
        checkOutput("midRstMsgReady",  256'(msg_ready),      256'd0);
        checkOutput("midRstCoreValid", 256'(core_in_valid),  256'd0);
        checkOutput("midRstOutReady",  256'(core_out_ready), 256'd0);
        checkOutput("midRstDigValid",  256'(digest_valid),   256'd0);
        checkOutput("midRstDigest",    digest,               256'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        base = blkLog.size();
        coreHold = 1'b1;
        msgWords[0] = 32'h61626300;
        applyStimulus(1, 2'd3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("holdCoreValid", 256'(core_in_valid), 256'd0);
            @(negedge clk_i);
        end
        coreHold = 1'b0;
        collectDigest("postRstAbc", ABC_DIG, 1'b1);
        checkOutput("postRstNh", 256'(nhLog[base]), 256'd1);

`ifdef SHA256_PAD_PERF_EN
        loadTwoBlockText();
        applyStimulus(14, 2'd0, 1'b0, 1'b1);
        collectDigest("perfTwo", TWO_DIG, 1'b1);
        clearWords();
        applyStimulus(16, 2'd0, 1'b0, 1'b1);
        collectDigest("perfZ64", '0, 1'b0);
        checkOutput("blkCount", 256'(blk_count), 256'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
